alb_pipe: RTL and testbench

//  Parametrised, pipelined successor to the 8-bit ALB arithmetic/logic block: WIDTH-bit operands,
//  3-bit mode (8 ops), registered C/Z/N/V flags, valid/ready handshakes on both sides.

---
 rtl/alb_pkg.sv | 22 ++
 rtl/alb_core.sv | 70 +++++++
 rtl/alb_pipe.sv | 130 +++++++++++++
 tb/tb_alb_pipe.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alb_pkg.sv
// Shared definitions for the pipelined ALB: operation codes and the flag bundle.
package alb_pkg;

  // Operation select codes carried on the 3-bit mode input.
  localparam logic [2:0] ALB_SUB  = 3'b000;
  localparam logic [2:0] ALB_AND  = 3'b001;
  localparam logic [2:0] ALB_ADD  = 3'b010;
  localparam logic [2:0] ALB_OR   = 3'b011;
  localparam logic [2:0] ALB_XOR  = 3'b100;
  localparam logic [2:0] ALB_PASS = 3'b101;
  localparam logic [2:0] ALB_SHL  = 3'b110;
  localparam logic [2:0] ALB_SHR  = 3'b111;

  // Carry, zero, negative and overflow of one result, kept together through the pipe.
  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } alb_flags_t;

endpackage

// File: rtl/alb_core.sv
// Combinational WIDTH-bit operation and flag unit of the ALB.
// Arithmetic is done one bit wider than the operands so the carry falls out as the top bit.
module alb_core
  import alb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic             ci_i,
  input  logic [2:0]       mode_i,
  output logic [WIDTH-1:0] f_o,
  output alb_flags_t       flags_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   ci_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] f;
  logic             c;
  logic             v;

  assign ci_ext = {{WIDTH{1'b0}}, ci_i};

  // Select the operation, then derive carry and overflow for it.
  // NOTE: every variable gets a default at the top of an always_comb so no path can
  // leave it unassigned; a missing default is how latches get inferred.
  always_comb begin
    sum = '0;
    f   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (mode_i)
      ALB_SUB: begin
        // SUB is R + ~S + CI, so CO=1 means no borrow occurred.
        sum = {1'b0, r_i} + {1'b0, ~s_i} + ci_ext;
        f   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (r_i[MSB] != s_i[MSB]) && (f[MSB] != r_i[MSB]);
      end
      ALB_ADD: begin
        sum = {1'b0, r_i} + {1'b0, s_i} + ci_ext;
        f   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (r_i[MSB] == s_i[MSB]) && (f[MSB] != r_i[MSB]);
      end
      ALB_AND:  f = r_i & s_i;
      ALB_OR:   f = r_i | s_i;
      ALB_XOR:  f = r_i ^ s_i;
      ALB_PASS: f = r_i;
      ALB_SHL: begin
        f = {r_i[WIDTH-2:0], ci_i};
        c = r_i[MSB];
      end
      ALB_SHR: begin
        f = {ci_i, r_i[WIDTH-1:1]};
        c = r_i[0];
      end
      default: f = '0;
    endcase
  end

  assign f_o       = f;
  assign flags_o.c = c;
  assign flags_o.z = (f == '0);
  assign flags_o.n = f[MSB];
  assign flags_o.v = v;

endmodule

// File: rtl/alb_pipe.sv
// Two-stage pipelined ALB with valid/ready handshakes on both sides.
// S1 holds the operands, S2 holds the registered result and flags. A result that
// is not taken stalls the whole pipe, so order is kept and nothing is dropped.
module alb_pipe
  import alb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] R_in,
  input  logic [WIDTH-1:0] S_in,
  input  logic             CI_in,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             CO,
  output logic             ZO,
  output logic             NO,
  output logic             VO,
  output logic             vo_sticky,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] xfer_cnt
);

  // Stage 1: captured operands.
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_r_q;
  logic [WIDTH-1:0] s1_s_q;
  logic             s1_ci_q;
  logic [2:0]       s1_mode_q;

  // Stage 2: registered result.
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_f_q;
  alb_flags_t       s2_flags_q;

  // Core outputs computed from stage 1.
  logic [WIDTH-1:0] core_f;
  alb_flags_t       core_flags;

  logic             stall;
  logic             xfer;
  logic             sticky_d, sticky_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  alb_core #(.WIDTH(WIDTH)) u_core (
    .r_i     (s1_r_q),
    .s_i     (s1_s_q),
    .ci_i    (s1_ci_q),
    .mode_i  (s1_mode_q),
    .f_o     (core_f),
    .flags_o (core_flags)
  );

  // A held result blocks both stages; the upstream sees that immediately.
  assign stall    = s2_valid_q && !out_ready;
  assign in_ready = !stall;
  assign xfer     = s2_valid_q && out_ready;

  // Stage 1 register: take a new beat (or a bubble) whenever the pipe moves.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
      s1_s_q     <= '0;
      s1_ci_q    <= 1'b0;
      s1_mode_q  <= ALB_SUB;
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_r_q    <= R_in;
        s1_s_q    <= S_in;
        s1_ci_q   <= CI_in;
        s1_mode_q <= mode;
      end
    end
  end

  // Stage 2 register: capture the core result; F and flags hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_f_q     <= '0;
      s2_flags_q <= '0;
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_f_q     <= core_f;
        s2_flags_q <= core_flags;
      end
    end
  end

  // Next state of the sticky overflow and transfer counter; a set beats a clear.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr_sticky) sticky_d = 1'b0;
    if (xfer && s2_flags_q.v) sticky_d = 1'b1;
    if (xfer) cnt_d = cnt_q + 1'b1;
  end

  // Sticky overflow and wrapping transfer counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign F         = s2_f_q;
  assign CO        = s2_flags_q.c;
  assign ZO        = s2_flags_q.z;
  assign NO        = s2_flags_q.n;
  assign VO        = s2_flags_q.v;
  assign vo_sticky = sticky_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_alb_pipe.sv
// Directed bench for alb_pipe. A default instance (CNT_W=16) and a CNT_W=4 instance
// share all inputs; the narrow one is used to observe counter wrap.
module tb_alb_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] R_in = '0;
  logic [7:0] S_in = '0;
  logic       CI_in = 1'b0;
  logic [2:0] mode = 3'b000;
  logic       out_ready = 1'b1;
  logic       clr_sticky = 1'b0;

  logic        in_ready, out_valid, CO, ZO, NO, VO, vo_sticky;
  logic [7:0]  F;
  logic [15:0] xfer_cnt;

  logic        in_ready4, out_valid4, CO4, ZO4, NO4, VO4, vo_sticky4;
  logic [7:0]  F4;
  logic [3:0]  xfer_cnt4;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [15:0] exp_cnt = '0;
  logic [3:0]  exp_cnt4;

  // Sampled by run_single.
  logic       v_early, v_late;
  logic [7:0] got_f;
  logic [3:0] got_czv;

  always #5 clk = ~clk;

  alb_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .R_in(R_in), .S_in(S_in), .CI_in(CI_in), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .F(F),
    .CO(CO), .ZO(ZO), .NO(NO), .VO(VO),
    .vo_sticky(vo_sticky), .clr_sticky(clr_sticky), .xfer_cnt(xfer_cnt)
  );

  alb_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .R_in(R_in), .S_in(S_in), .CI_in(CI_in), .mode(mode),
    .out_valid(out_valid4), .out_ready(out_ready), .F(F4),
    .CO(CO4), .ZO(ZO4), .NO(NO4), .VO(VO4),
    .vo_sticky(vo_sticky4), .clr_sticky(clr_sticky), .xfer_cnt(xfer_cnt4)
  );

  typedef struct {
    string      name;
    logic [2:0] m;
    logic [7:0] r;
    logic [7:0] s;
    logic       ci;
    logic [7:0] f;
    logic [3:0] czv; // {C,Z,N,V}
  } vec_t;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;
    tick();
    tick();
    reset   = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic drive(input logic [2:0] m, input logic [7:0] r, input logic [7:0] s,
                       input logic ci);
    in_valid = 1'b1;
    mode     = m;
    R_in     = r;
    S_in     = s;
    CI_in    = ci;
  endtask

  // One beat through an idle pipe with out_ready=1: records out_valid after the
  // accepting edge and after the next one, the result seen then, and lets it transfer.
  task automatic run_single(input logic [2:0] m, input logic [7:0] r, input logic [7:0] s,
                            input logic ci);
    out_ready = 1'b1;
    drive(m, r, s, ci);
    tick();
    in_valid = 1'b0;
    v_early  = out_valid;
    tick();
    v_late  = out_valid;
    got_f   = F;
    got_czv = {CO, ZO, NO, VO};
    tick();
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    do_reset();
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (F !== 8'h00) begin n_fail++; $display("FAIL reset_F got=%h exp=00", F); end
    n_checks++;
    if ({CO, ZO, NO, VO} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0000", {CO, ZO, NO, VO});
    end
    n_checks++;
    if (vo_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got=%b exp=0", vo_sticky); end
    n_checks++;
    if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", xfer_cnt); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
  endtask

  task automatic test_add_overflow();
    run_single(3'b010, 8'h7F, 8'h01, 1'b0);
    n_checks++;
    if (v_early !== 1'b0) begin n_fail++; $display("FAIL add_ovf_early got=%b exp=0", v_early); end
    n_checks++;
    if (v_late !== 1'b1) begin n_fail++; $display("FAIL add_ovf_valid got=%b exp=1", v_late); end
    n_checks++;
    if (got_f !== 8'h80) begin n_fail++; $display("FAIL add_ovf_F got=%h exp=80", got_f); end
    n_checks++;
    if (got_czv !== 4'b0011) begin n_fail++; $display("FAIL add_ovf_flags got=%b exp=0011", got_czv); end
    n_checks++;
    if (vo_sticky !== 1'b1) begin n_fail++; $display("FAIL add_ovf_sticky got=%b exp=1", vo_sticky); end
    n_checks++;
    if (xfer_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL add_ovf_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt);
    end
  endtask

  task automatic test_ops();
    vec_t vecs[13];
    vecs = '{
      '{"sub_eq",     3'b000, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1100},
      '{"sub_borrow", 3'b000, 8'h00, 8'h01, 1'b1, 8'hFF, 4'b0010},
      '{"sub_ovf",    3'b000, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b1001},
      '{"sub_ci0",    3'b000, 8'h05, 8'h03, 1'b0, 8'h01, 4'b1000},
      '{"add_carry",  3'b010, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1100},
      '{"add_ci_ovf", 3'b010, 8'h40, 8'h40, 1'b1, 8'h81, 4'b0011},
      '{"and",        3'b001, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000},
      '{"or",         3'b011, 8'h0F, 8'h80, 1'b0, 8'h8F, 4'b0010},
      '{"xor",        3'b100, 8'hA5, 8'hFF, 1'b0, 8'h5A, 4'b0000},
      '{"pass",       3'b101, 8'h00, 8'hFF, 1'b1, 8'h00, 4'b0100},
      '{"shl",        3'b110, 8'h81, 8'h00, 1'b1, 8'h03, 4'b1000},
      '{"shr_zero",   3'b111, 8'h01, 8'h00, 1'b0, 8'h00, 4'b1100},
      '{"shr_ci",     3'b111, 8'h80, 8'h00, 1'b1, 8'hC0, 4'b0010}
    };
    foreach (vecs[i]) begin
      run_single(vecs[i].m, vecs[i].r, vecs[i].s, vecs[i].ci);
      n_checks++;
      if (v_early !== 1'b0 || v_late !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_latency got=%b%b exp=01", vecs[i].name, v_early, v_late);
      end
      n_checks++;
      if (got_f !== vecs[i].f) begin
        n_fail++; $display("FAIL %s_F got=%h exp=%h", vecs[i].name, got_f, vecs[i].f);
      end
      n_checks++;
      if (got_czv !== vecs[i].czv) begin
        n_fail++; $display("FAIL %s_flags got=%b exp=%b", vecs[i].name, got_czv, vecs[i].czv);
      end
    end
    n_checks++;
    if (xfer_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL ops_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_f[3];
    exp_f = '{8'h03, 8'h30, 8'h45};
    out_ready = 1'b0;
    drive(3'b010, 8'h01, 8'h02, 1'b0);
    tick();
    drive(3'b010, 8'h10, 8'h20, 1'b0);
    tick();
    drive(3'b010, 8'h40, 8'h05, 1'b0);
    // Result A is now held; beat C waits on the input.
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || F !== exp_f[0]) begin
        n_fail++;
        $display("FAIL b2b_stall%0d in_ready=%b out_valid=%b F=%h exp 0 1 %h",
                 k, in_ready, out_valid, F, exp_f[0]);
      end
      if (k < 3) tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_release got=%b exp=1", in_ready); end
    for (int k = 1; k < 3; k++) begin
      tick();
      in_valid = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      n_checks++;
      if (out_valid !== 1'b1 || F !== exp_f[k]) begin
        n_fail++;
        $display("FAIL b2b_order%0d out_valid=%b F=%h exp 1 %h", k, out_valid, F, exp_f[k]);
      end
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    n_checks++;
    if (xfer_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL b2b_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_flush();
    do_reset();
    out_ready = 1'b0;
    drive(3'b010, 8'h7F, 8'h01, 1'b0);
    tick();
    drive(3'b010, 8'h11, 8'h22, 1'b0);
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset     = 1'b0;
    exp_cnt   = '0;
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=0", xfer_cnt); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || xfer_cnt !== 16'd0 || vo_sticky !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_idle%0d out_valid=%b cnt=%0d sticky=%b exp 0 0 0",
                 k, out_valid, xfer_cnt, vo_sticky);
      end
    end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(3'b010, 8'h00, 8'h00, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    exp_cnt  = exp_cnt + 16'd16;
    exp_cnt4 = exp_cnt[3:0];
    n_checks++;
    if (xfer_cnt4 !== exp_cnt4) begin
      n_fail++; $display("FAIL wrap_cnt4 got=%0d exp=%0d", xfer_cnt4, exp_cnt4);
    end
    n_checks++;
    if (xfer_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL wrap_cnt16 got=%0d exp=%0d", xfer_cnt, exp_cnt);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sticky();
    do_reset();
    // A non-overflowing transfer leaves the flag clear.
    run_single(3'b010, 8'h01, 8'h01, 1'b0);
    n_checks++;
    if (vo_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_noset got=%b exp=0", vo_sticky); end
    // Overflowing transfer coincides with clr_sticky: set wins.
    out_ready = 1'b1;
    drive(3'b010, 8'h7F, 8'h01, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    n_checks++;
    if (vo_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky_race got=%b exp=1", vo_sticky); end
    // A plain clear with nothing transferring drops it.
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    n_checks++;
    if (vo_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_clear got=%b exp=0", vo_sticky); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_ops();
    test_back_to_back();
    test_reset_flush();
    test_cnt_wrap();
    test_sticky();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
